// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM stage with accelerator arbitration.
// FSM state encoding, region codes and the region-to-channel mapping.
package mem_stage_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MEM_ACC,
        MEM_RSP,
        ACC_START,
        ACC_WAIT,
        DONE
    } state_t;

    localparam logic [1:0] REG_MEM   = 2'd0;
    localparam logic [1:0] REG_ACC   = 2'd1;
    localparam logic [1:0] REG_UNMAP = 2'd2;

    localparam logic [2:0] ACC_REGION_TOP = 3'b111;

    // Channels count downward from the top region: 3'b111 is channel 0.
    function automatic logic [2:0] region_to_chan(input logic [2:0] region);
        return ACC_REGION_TOP - region;
    endfunction

endpackage

// File: rtl/mem_stage_region_dec.sv
// Combinational region decoder: accelerator hit vector, channel index and
// region class. Accelerator channels take priority over memory.
module mem_stage_region_dec
    import mem_stage_pkg::*;
#(
    parameter int NUM_ACC = 2
) (
    input  logic [2:0]         i_region,
    input  logic               i_mem_read,
    input  logic               i_mem_write,
    output logic [NUM_ACC-1:0] o_hit,
    output logic [2:0]         o_chan,
    output logic [1:0]         o_region
);

    // Map region to channel, flag the hit and classify the request.
    always_comb begin
        o_chan = region_to_chan(i_region);
        o_hit  = '0;
        for (int i = 0; i < NUM_ACC; i++) begin
            o_hit[i] = (o_chan == 3'(i));
        end
        if (|o_hit) begin
            o_region = REG_ACC;
        end else if (i_mem_read || i_mem_write) begin
            o_region = REG_MEM;
        end else begin
            o_region = REG_UNMAP;
        end
    end

endmodule

// File: rtl/mem_stage_acc_arb.sv
// MEM stage sequencing data memory and accelerator channels, one op at a time.
// Optional accelerator watchdog: define MEM_STAGE_ACC_TIMEOUT_EN.
module mem_stage_acc_arb
    import mem_stage_pkg::*;
#(
    parameter int DATA_W  = 19,
    parameter int ADDR_W  = 19,
    parameter int NUM_ACC = 2,
    parameter int ACC_AW  = 10
`ifdef MEM_STAGE_ACC_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 1024
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [DATA_W-1:0]  wdata,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [DATA_W-1:0]  rs2_data,
    input  logic [DATA_W-1:0]  rd_data,
    output logic               dmem_en,
    output logic               dmem_we,
    output logic [ADDR_W-1:0]  dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic [DATA_W-1:0]  dmem_rdata,
    output logic [NUM_ACC-1:0] acc_start,
    output logic [ACC_AW-1:0]  acc_src,
    output logic [ACC_AW-1:0]  acc_dst,
    input  logic [NUM_ACC-1:0] acc_done,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic [1:0]         out_region,
`ifdef MEM_STAGE_ACC_TIMEOUT_EN
    output logic               acc_timeout,
`endif
    output logic [NUM_ACC-1:0] acc_busy
);

    state_t               r_state;
    logic                 r_in_ready;
    logic                 r_is_load;
    logic                 r_dmem_en;
    logic                 r_dmem_we;
    logic [ADDR_W-1:0]    r_dmem_addr;
    logic [DATA_W-1:0]    r_dmem_wdata;
    logic [NUM_ACC-1:0]   r_acc_start;
    logic [NUM_ACC-1:0]   r_acc_busy;
    logic [ACC_AW-1:0]    r_acc_src;
    logic [ACC_AW-1:0]    r_acc_dst;
    logic                 r_out_valid;
    logic [DATA_W-1:0]    r_out_data;
    logic [1:0]           r_out_region;
`ifdef MEM_STAGE_ACC_TIMEOUT_EN
    logic [31:0]          r_to_cnt;
    logic                 r_acc_timeout;
`endif

    logic [NUM_ACC-1:0]   w_hit;
    logic [2:0]           w_chan;
    logic [1:0]           w_region;
    logic                 w_accept;
    logic                 w_unused;

    mem_stage_region_dec #(
        .NUM_ACC (NUM_ACC)
    ) u_dec (
        .i_region    (addr[ADDR_W-1 -: 3]),
        .i_mem_read  (mem_read),
        .i_mem_write (mem_write),
        .o_hit       (w_hit),
        .o_chan      (w_chan),
        .o_region    (w_region)
    );

    assign w_accept = in_valid && r_in_ready;
    assign w_unused = ^{rs2_data, rd_data, w_chan};

    // Request sequencer: captures the request on acceptance and walks it
    // through its target path; all outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_in_ready   <= 1'b1;
            r_is_load    <= 1'b0;
            r_dmem_en    <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
            r_acc_start  <= '0;
            r_acc_busy   <= '0;
            r_acc_src    <= '0;
            r_acc_dst    <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_region <= '0;
`ifdef MEM_STAGE_ACC_TIMEOUT_EN
            r_to_cnt      <= '0;
            r_acc_timeout <= 1'b0;
`endif
        end else begin
            r_dmem_en   <= 1'b0;
            r_dmem_we   <= 1'b0;
            r_acc_start <= '0;
            r_out_valid <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_in_ready   <= 1'b0;
                        r_out_data   <= '0;
                        r_out_region <= w_region;
                        if (w_region == REG_ACC) begin
                            r_state     <= ACC_START;
                            r_acc_start <= w_hit;
                            r_acc_busy  <= w_hit;
                            r_acc_src   <= rs2_data[ACC_AW-1:0];
                            r_acc_dst   <= rd_data[ACC_AW-1:0];
                        end else if (w_region == REG_MEM) begin
                            r_state      <= MEM_ACC;
                            r_dmem_en    <= 1'b1;
                            r_dmem_we    <= mem_write;
                            r_dmem_addr  <= addr;
                            r_dmem_wdata <= wdata;
                            r_is_load    <= mem_read && !mem_write;
                        end else begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                MEM_ACC: begin
                    r_state <= MEM_RSP;
                end
                MEM_RSP: begin
                    if (r_is_load) begin
                        r_out_data <= dmem_rdata;
                    end
                    r_state     <= DONE;
                    r_out_valid <= 1'b1;
                end
                ACC_START: begin
                    r_state <= ACC_WAIT;
`ifdef MEM_STAGE_ACC_TIMEOUT_EN
                    r_to_cnt <= '0;
`endif
                end
                ACC_WAIT: begin
                    if (|(acc_done & r_acc_busy)) begin
                        r_acc_busy  <= '0;
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                    end
`ifdef MEM_STAGE_ACC_TIMEOUT_EN
                    else if (r_to_cnt == 32'(TIMEOUT_CYC - 1)) begin
                        r_acc_busy    <= '0;
                        r_state       <= DONE;
                        r_out_valid   <= 1'b1;
                        r_out_data    <= '1;
                        r_acc_timeout <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + 32'd1;
                    end
`endif
                end
                DONE: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b1;
                end
                default: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign dmem_en    = r_dmem_en;
    assign dmem_we    = r_dmem_we;
    assign dmem_addr  = r_dmem_addr;
    assign dmem_wdata = r_dmem_wdata;
    assign acc_start  = r_acc_start;
    assign acc_busy   = r_acc_busy;
    assign acc_src    = r_acc_src;
    assign acc_dst    = r_acc_dst;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_region = r_out_region;
`ifdef MEM_STAGE_ACC_TIMEOUT_EN
    assign acc_timeout = r_acc_timeout;
`endif

endmodule

// File: doc/mem_stage_acc_arb.md
Name: mem_stage_acc_arb

Overview:
- Parametrised successor of the pipeline MEM stage. Decodes each request's address into one of three targets: data memory, or one of NUM_ACC accelerator channels (FFT, crypto, ...).
- Sequences the request with a valid/ready handshake and stalls the pipeline until the target completes.
- Sits between EX/MEM and MEM/WB registers. Drives a synchronous 1-cycle-latency data memory and per-channel accelerator start/done ports.

Parameters:
- DATA_W, 19, datapath width.
- ADDR_W, 19, address width; region field is addr[ADDR_W-1 -: 3].
- NUM_ACC, 2, accelerator channels (1..6). Channel i decodes region 3'b111 - i, so default channel 0 = FFT at 3'b111 and channel 1 = crypto at 3'b110.
- ACC_AW, 10, accelerator source/result address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request present from EX/MEM.
- in_ready  out  1  stage can accept; low = stall upstream.
- addr  in  ADDR_W  effective address.
- wdata  in  DATA_W  store data.
- mem_read  in  1  load request.
- mem_write  in  1  store request.
- rs2_data  in  DATA_W  accelerator source address (low ACC_AW bits used).
- rd_data  in  DATA_W  accelerator result address (low ACC_AW bits used).
- dmem_en  out  1  memory access strobe.
- dmem_we  out  1  memory write enable.
- dmem_addr  out  ADDR_W  memory address.
- dmem_wdata  out  DATA_W  memory write data.
- dmem_rdata  in  DATA_W  memory read data, valid the cycle after dmem_en.
- acc_start  out  NUM_ACC  one-hot, one-cycle start pulse.
- acc_src  out  ACC_AW  source address to accelerator.
- acc_dst  out  ACC_AW  result address to accelerator.
- acc_done  in  NUM_ACC  per-channel completion pulse.
- out_valid  out  1  result to MEM/WB, one-cycle pulse.
- out_data  out  DATA_W  load data (0 for stores and accelerator ops).
- out_region  out  2  0 = mem, 1 = accelerator, 2 = unmapped.
- acc_busy  out  NUM_ACC  channel currently running.

Behaviour:
- Reset (async, rst_n low): state IDLE. All outputs 0 except in_ready = 1. Any operation in flight is abandoned and no out_valid is emitted for it.
- Accept: transfer occurs when in_valid && in_ready. Request fields are registered on acceptance. in_ready = 1 only in IDLE.
- Decode of registered region r:
  - r == 3'b111 - i for i < NUM_ACC → channel i.
  - Else, if mem_read or mem_write → memory.
  - Else → unmapped.
- Channel decode wins over memory.
- FSM states: IDLE, MEM_ACC, MEM_RSP, ACC_START, ACC_WAIT, DONE.
- Memory path: IDLE → MEM_ACC (dmem_en = 1; dmem_we = mem_write; address and data from registered request) → MEM_RSP (capture dmem_rdata if load) → DONE. Load-to-out_valid latency is 3 cycles from acceptance.
- mem_read and mem_write both set: treated as a write; out_data = 0.
- Accelerator path: IDLE → ACC_START, one-cycle acc_start[i] pulse with acc_src = rs2_data[ACC_AW-1:0] and acc_dst = rd_data[ACC_AW-1:0]. acc_busy[i] sets at the same cycle.
  - ACC_START → ACC_WAIT.
  - ACC_WAIT stays until acc_done[i], then clears acc_busy[i] and goes to DONE.
  - acc_done asserted in the same cycle as acc_start is ignored.
  - acc_done on a non-selected channel is ignored.
- Unmapped path: IDLE → DONE directly, out_region = 2, no side effects.
- DONE: out_valid = 1 for one cycle with out_data and out_region, then → IDLE. A new request can be accepted the following cycle, so there is no back-to-back acceptance.
- Only one operation is in flight at a time; the FSM does not re-check in_valid before returning to IDLE.

Optional Feature:
- Macro: MEM_STAGE_ACC_TIMEOUT_EN.
- When defined:
  - Adds parameter TIMEOUT_CYC (default 1024) and output acc_timeout (1 bit, sticky, reset 0).
  - A counter runs in ACC_WAIT. When it reaches TIMEOUT_CYC-1 without acc_done: FSM → DONE, acc_busy[i] clears, acc_timeout sets, out_region = 1, out_data = all-ones.
  - acc_done arriving in the same cycle as the timeout wins; normal completion.
- When not defined: no counter, no port, and ACC_WAIT waits indefinitely.

Decomposition:
- Package mem_stage_pkg holds:
  - FSM state enum.
  - Region codes REG_MEM = 0, REG_ACC = 1, REG_UNMAP = 2.
  - Constant ACC_REGION_TOP = 3'b111.
  - Function region_to_chan.
- One natural sub-module: mem_stage_region_dec. Combinational decode of region field plus mem_read/mem_write into hit vector, channel index and region code. Reused by the hazard unit.

Test Plan:
- Store addr=0x00010, wdata=0x5A5A5, then load same addr → dmem_we pulse with 0x5A5A5; the load returns out_valid 3 cycles after acceptance with out_data = 0x5A5A5, out_region = 0.
- addr=0x70000 (region 111), rs2=0x123, rd=0x2AB → acc_start = 2'b01 for one cycle, acc_src = 0x123, acc_dst = 0x2AB, in_ready low. acc_done[0] after 20 cycles → out_valid next cycle, acc_busy = 0.
- addr=0x60000 with acc_done[0] pulsed during wait → ignored. acc_done[1] completes the op, out_region = 1.
- addr=0x50000, no read/write → out_valid 1 cycle after acceptance, out_region = 2, dmem_en and acc_start never asserted.
- rst_n low during ACC_WAIT → all outputs at reset values immediately, in_ready = 1; no out_valid after release.
- With MEM_STAGE_ACC_TIMEOUT_EN and TIMEOUT_CYC = 8: no acc_done → out_valid with out_data = 0x7FFFF, acc_timeout = 1 and held.
